// File: rtl/lcd_fb_arbiter.sv
// Frame-buffer port arbiter: LCD scan-out reads take priority over a pixel writer.
// Double-buffered pages; a requested swap only takes effect on the next frame start.
module lcd_fb_arbiter #(
    parameter int H_DISP     = 480,
    parameter int V_DISP     = 272,
    parameter int PAGE_WORDS = 130560,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [11:0]       disp_x,
    input  logic [11:0]       disp_y,
    input  logic              lcd_vs,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [11:0]       wr_x,
    input  logic [11:0]       wr_y,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              swap_req,
    output logic              swap_done,
    output logic              front_page,
    output logic              err_oob,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [11:0]       X_LIM    = 12'(H_DISP);
    localparam logic [11:0]       Y_LIM    = 12'(V_DISP);
    localparam logic [ADDR_W-1:0] LINE_MUL = ADDR_W'(H_DISP);
    localparam logic [ADDR_W-1:0] PAGE_OFF = ADDR_W'(PAGE_WORDS);

    typedef enum logic {
        IDLE,
        PENDING
    } swap_state_t;

    swap_state_t       r_state;
    swap_state_t       w_next_state;
    logic              w_swap_apply;
    logic              w_wr_ready;
    logic              w_wr_accept;
    logic              w_fs;
    logic              w_rd_in_range;
    logic              w_wr_in_range;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_wr_addr;

    logic              r_vs_d;
    logic              r_front_page;
    logic              r_swap_done;
    logic              r_err_oob;
    logic              r_p1_valid;
    logic              r_p1_inr;
    logic              r_p2_valid;
    logic              r_p2_inr;
    logic              r_disp_valid;
    logic [DATA_W-1:0] r_disp_data;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;

    assign w_fs = r_vs_d & ~lcd_vs;

    assign w_rd_in_range = (disp_x < X_LIM) && (disp_y < Y_LIM);
    assign w_wr_in_range = (wr_x < X_LIM) && (wr_y < Y_LIM);

    // Reads use the front page, writes the back page; full ADDR_W arithmetic avoids truncation.
    assign w_rd_addr = (r_front_page ? PAGE_OFF : '0)
                     + ADDR_W'(disp_y) * LINE_MUL + ADDR_W'(disp_x);
    assign w_wr_addr = (r_front_page ? '0 : PAGE_OFF)
                     + ADDR_W'(wr_y) * LINE_MUL + ADDR_W'(wr_x);

    always_comb begin
        w_next_state = r_state;
        w_swap_apply = 1'b0;
        w_wr_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                w_wr_ready = !rst && !disp_req;
                if (swap_req) begin
                    w_next_state = PENDING;
                end
            end
            PENDING: begin
                if (w_fs) begin
                    w_next_state = IDLE;
                    w_swap_apply = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_wr_accept = wr_valid && w_wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_vs_d       <= 1'b1;
            r_front_page <= 1'b0;
            r_swap_done  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_vs_d      <= lcd_vs;
            r_swap_done <= w_swap_apply;
            if (w_swap_apply) begin
                r_front_page <= ~r_front_page;
            end
        end
    end

    // Fixed three-stage read pipeline: issue, RAM latency, capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1_valid   <= 1'b0;
            r_p1_inr     <= 1'b0;
            r_p2_valid   <= 1'b0;
            r_p2_inr     <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disp_data  <= '0;
        end else begin
            r_p1_valid   <= disp_req;
            r_p1_inr     <= disp_req && w_rd_in_range;
            r_p2_valid   <= r_p1_valid;
            r_p2_inr     <= r_p1_inr;
            r_disp_valid <= r_p2_valid;
            r_disp_data  <= r_p2_inr ? ram_rdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_err_oob   <= 1'b0;
        end else begin
            if (disp_req && w_rd_in_range) begin
                r_ram_en   <= 1'b1;
                r_ram_we   <= 1'b0;
                r_ram_addr <= w_rd_addr;
            end else if (w_wr_accept && w_wr_in_range) begin
                r_ram_en    <= 1'b1;
                r_ram_we    <= 1'b1;
                r_ram_addr  <= w_wr_addr;
                r_ram_wdata <= wr_data;
            end else begin
                r_ram_en <= 1'b0;
                r_ram_we <= 1'b0;
            end
            if (w_wr_accept && !w_wr_in_range) begin
                r_err_oob <= 1'b1;
            end
        end
    end

    assign wr_ready   = w_wr_ready;
    assign disp_data  = r_disp_data;
    assign disp_valid = r_disp_valid;
    assign swap_done  = r_swap_done;
    assign front_page = r_front_page;
    assign err_oob    = r_err_oob;
    assign ram_en     = r_ram_en;
    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Bench for lcd_fb_arbiter: behavioural RAM, directed scenarios and a randomized run
// checked against a page/pixel-level model of the frame buffer.
module tb_lcd_fb_arbiter;

    localparam int PW = 130560;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_req;
    logic [11:0] disp_x;
    logic [11:0] disp_y;
    logic        lcd_vs;
    logic [23:0] disp_data;
    logic        disp_valid;
    logic        wr_valid;
    logic        wr_ready;
    logic [11:0] wr_x;
    logic [11:0] wr_y;
    logic [23:0] wr_data;
    logic        swap_req;
    logic        swap_done;
    logic        front_page;
    logic        err_oob;
    logic        ram_en;
    logic        ram_we;
    logic [17:0] ram_addr;
    logic [23:0] ram_wdata;
    logic [23:0] ram_rdata = '0;

    int nCompared = 0;
    int nMismatched = 0;

    logic        pokeValid = 1'b0;
    int          pokeAddr = 0;
    logic [23:0] pokeData = '0;
    logic [23:0] ramMem [int];

    typedef struct {
        int          due;
        logic [23:0] data;
    } exp_t;

    lcd_fb_arbiter dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y), .lcd_vs(lcd_vs),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .swap_req(swap_req), .swap_done(swap_done), .front_page(front_page), .err_oob(err_oob),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pattern(input int a);
        return 24'(a * 37 + 4951) ^ 24'h800000;
    endfunction

    // Single-port RAM with one-cycle read latency; unwritten words read back a fixed pattern.
    always @(posedge clk) begin
        if (pokeValid) ramMem[pokeAddr] = pokeData;
        if (ram_en) begin
            if (ram_we) ramMem[int'(ram_addr)] = ram_wdata;
            else ram_rdata <= ramMem.exists(int'(ram_addr)) ? ramMem[int'(ram_addr)] : pattern(int'(ram_addr));
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idleInputs();
        disp_req = 0; disp_x = 0; disp_y = 0;
        wr_valid = 0; wr_x = 0; wr_y = 0; wr_data = 0;
        swap_req = 0;
    endtask

    task automatic test_reset();
        idleInputs();
        lcd_vs = 1; rst = 1; wr_valid = 1; disp_req = 1; swap_req = 1;
        wr_x = 5; wr_y = 2; disp_x = 5; disp_y = 2;
        repeat (2) @(negedge clk);
        chk("rst_disp_valid", 32'(disp_valid), 0);
        chk("rst_disp_data", 32'(disp_data), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_swap_done", 32'(swap_done), 0);
        chk("rst_front_page", 32'(front_page), 0);
        chk("rst_err_oob", 32'(err_oob), 0);
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        rst = 0;
        idleInputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_ram_en", 32'(ram_en), 0);
            chk("post_rst_front", 32'(front_page), 0);
        end
    endtask

    task automatic test_read_latency();
        logic [23:0] q[$];
        int validCnt = 0, run = 0, maxRun = 0, dataErr = 0;
        pokeAddr = 965; pokeData = 24'hABCDEF; pokeValid = 1;
        @(negedge clk);
        pokeValid = 0;
        disp_req = 1; disp_x = 5; disp_y = 2;
        @(negedge clk);
        disp_req = 0;
        chk("rd_ram_en", 32'(ram_en), 1);
        chk("rd_ram_we", 32'(ram_we), 0);
        chk("rd_ram_addr", 32'(ram_addr), 965);
        @(negedge clk);
        chk("rd_valid_t2", 32'(disp_valid), 0);
        @(negedge clk);
        chk("rd_valid_t3", 32'(disp_valid), 1);
        chk("rd_data_t3", 32'(disp_data), 32'h00ABCDEF);
        @(negedge clk);
        chk("rd_valid_t4", 32'(disp_valid), 0);
        for (int i = 0; i < 484; i++) begin
            if (i < 480) begin
                disp_req = 1; disp_x = 12'(i); disp_y = 0;
                q.push_back(pattern(i));
            end else begin
                disp_req = 0;
            end
            @(negedge clk);
            if (disp_valid) begin
                validCnt++; run++;
                if (run > maxRun) maxRun = run;
                if (q.size() == 0 || disp_data !== q[0]) dataErr++;
                if (q.size() > 0) void'(q.pop_front());
            end else begin
                run = 0;
            end
        end
        chk("burst_valid_count", 32'(validCnt), 480);
        chk("burst_max_run", 32'(maxRun), 480);
        chk("burst_data_errors", 32'(dataErr), 0);
    endtask

    task automatic test_priority_write();
        wr_valid = 1; wr_x = 5; wr_y = 2; wr_data = 24'h123456;
        for (int i = 0; i < 4; i++) begin
            disp_req = 1; disp_x = 1; disp_y = 1;
            #1;
            chk("prio_wr_ready_blocked", 32'(wr_ready), 0);
            @(negedge clk);
        end
        disp_req = 0;
        #1;
        chk("prio_wr_ready_free", 32'(wr_ready), 1);
        @(negedge clk);
        wr_valid = 0;
        chk("wr_ram_en", 32'(ram_en), 1);
        chk("wr_ram_we", 32'(ram_we), 1);
        chk("wr_ram_addr", 32'(ram_addr), 131525);
        chk("wr_ram_wdata", 32'(ram_wdata), 32'h00123456);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_swap();
        lcd_vs = 1;
        swap_req = 1;
        @(negedge clk);
        swap_req = 0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1;
            #1;
            chk("swap_pending_wr_ready", 32'(wr_ready), 0);
            chk("swap_pending_done", 32'(swap_done), 0);
            chk("swap_pending_front", 32'(front_page), 0);
            @(negedge clk);
        end
        wr_valid = 0;
        lcd_vs = 0;
        @(negedge clk);
        chk("swap_done_pulse", 32'(swap_done), 1);
        chk("swap_front_new", 32'(front_page), 1);
        @(negedge clk);
        chk("swap_done_single", 32'(swap_done), 0);
        disp_req = 1; disp_x = 0; disp_y = 0;
        @(negedge clk);
        disp_req = 0;
        chk("swap_rd_addr", 32'(ram_addr), 130560);
        chk("swap_rd_we", 32'(ram_we), 0);
        wr_valid = 1; wr_x = 0; wr_y = 0; wr_data = 24'h777777;
        #1;
        chk("swap_wr_ready", 32'(wr_ready), 1);
        @(negedge clk);
        wr_valid = 0;
        chk("swap_wr_addr", 32'(ram_addr), 0);
        chk("swap_wr_we", 32'(ram_we), 1);
        lcd_vs = 1;
        @(negedge clk);
    endtask

    task automatic test_swap_corners();
        int pulses = 0;
        lcd_vs = 0; swap_req = 1;
        @(negedge clk);
        swap_req = 0;
        chk("coinc_no_done", 32'(swap_done), 0);
        chk("coinc_front_hold", 32'(front_page), 1);
        #1;
        chk("coinc_pending_ready", 32'(wr_ready), 0);
        lcd_vs = 1;
        @(negedge clk);
        swap_req = 1;
        @(negedge clk);
        swap_req = 0;
        chk("second_req_front_hold", 32'(front_page), 1);
        lcd_vs = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (swap_done) pulses++;
        end
        chk("second_req_pulses", 32'(pulses), 1);
        chk("second_req_front", 32'(front_page), 0);
        lcd_vs = 1;
        @(negedge clk);
        lcd_vs = 0;
        repeat (2) @(negedge clk);
        chk("idle_fs_front", 32'(front_page), 0);
        chk("idle_fs_done", 32'(swap_done), 0);
        lcd_vs = 1;
        @(negedge clk);
    endtask

    task automatic test_oob();
        wr_valid = 1; wr_x = 480; wr_y = 0; wr_data = 24'hFFFFFF;
        #1;
        chk("oob_wr_ready", 32'(wr_ready), 1);
        @(negedge clk);
        wr_valid = 0;
        chk("oob_wr_ram_en", 32'(ram_en), 0);
        chk("oob_err_set", 32'(err_oob), 1);
        repeat (3) @(negedge clk);
        chk("oob_err_sticky", 32'(err_oob), 1);
        disp_req = 1; disp_x = 0; disp_y = 272;
        @(negedge clk);
        disp_req = 0;
        chk("oob_rd_ram_en", 32'(ram_en), 0);
        @(negedge clk);
        @(negedge clk);
        chk("oob_rd_valid", 32'(disp_valid), 1);
        chk("oob_rd_data", 32'(disp_data), 0);
    endtask

    task automatic test_random();
        exp_t        q[$];
        logic [23:0] fbModel [int];
        int          e = 0;
        bit          front = 0, pending = 0, errM = 0, expSd = 0, vsPrev = 1, wrPend = 0;
        bit          fs, expReady, inr;
        int          a;
        logic [23:0] d;
        idleInputs();
        lcd_vs = 1; rst = 1;
        @(negedge clk);
        rst = 0;
        for (int it = 0; it < 4000; it++) begin
            if (q.size() > 0 && q[0].due == e) begin
                chk("rnd_disp_valid", 32'(disp_valid), 1);
                chk("rnd_disp_data", 32'(disp_data), 32'(q[0].data));
                void'(q.pop_front());
            end else begin
                chk("rnd_disp_idle", 32'(disp_valid), 0);
            end
            chk("rnd_swap_done", 32'(swap_done), 32'(expSd));
            chk("rnd_front_page", 32'(front_page), 32'(front));
            chk("rnd_err_oob", 32'(err_oob), 32'(errM));
            if (ram_en && int'(ram_addr) >= 2 * PW) chk("rnd_ram_addr_bound", 32'(ram_addr), 0);

            disp_req = 1'($urandom_range(0, 1));
            disp_x = 12'($urandom_range(0, 7));
            disp_y = 12'($urandom_range(8, 11));
            if ($urandom_range(0, 9) == 0) disp_x = 12'($urandom_range(480, 499));
            if ($urandom_range(0, 9) == 0) disp_y = 12'($urandom_range(272, 276));
            if (!wrPend && $urandom_range(0, 2) == 0) begin
                wrPend = 1;
                wr_x = 12'($urandom_range(0, 7));
                wr_y = 12'($urandom_range(8, 11));
                if ($urandom_range(0, 15) == 0) wr_x = 12'($urandom_range(480, 490));
                if ($urandom_range(0, 15) == 0) wr_y = 12'($urandom_range(272, 280));
                wr_data = 24'($urandom);
            end
            wr_valid = wrPend;
            swap_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) lcd_vs = ~lcd_vs;
            #1;
            expReady = !disp_req && !pending;
            chk("rnd_wr_ready", 32'(wr_ready), 32'(expReady));

            fs = vsPrev && !lcd_vs;
            vsPrev = lcd_vs;
            if (disp_req) begin
                inr = (int'(disp_x) < 480) && (int'(disp_y) < 272);
                a = int'(front) * PW + int'(disp_y) * 480 + int'(disp_x);
                d = !inr ? 24'h0 : (fbModel.exists(a) ? fbModel[a] : pattern(a));
                q.push_back('{e + 3, d});
            end
            if (wr_valid && expReady) begin
                inr = (int'(wr_x) < 480) && (int'(wr_y) < 272);
                if (inr) fbModel[int'(!front) * PW + int'(wr_y) * 480 + int'(wr_x)] = wr_data;
                else errM = 1;
                wrPend = 0;
            end
            expSd = 0;
            if (pending && fs) begin
                pending = 0; front = !front; expSd = 1;
            end else if (!pending && swap_req) begin
                pending = 1;
            end
            @(negedge clk);
            e++;
        end
        idleInputs();
    endtask

    initial begin
        idleInputs();
        rst = 1;
        lcd_vs = 1;
        test_reset();
        test_read_latency();
        test_priority_write();
        test_swap();
        test_swap_corners();
        test_oob();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
